// File: rtl/atomic_req_arbiter_pkg.sv
// Shared atomic types: the operation encoding carried to atomic_unit and the
// request-slot state of the arbiter.
package atomic_types;

  localparam int OP_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WARP_W = 6;
  localparam int LANE_W = 5;

  typedef enum logic [OP_W-1:0] {
    ATOM_ADD  = 4'd0,
    ATOM_SUB  = 4'd1,
    ATOM_MIN  = 4'd2,
    ATOM_MAX  = 4'd3,
    ATOM_AND  = 4'd4,
    ATOM_OR   = 4'd5,
    ATOM_XOR  = 4'd6,
    ATOM_EXCH = 4'd7,
    ATOM_CAS  = 4'd8
  } atomic_op_e;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } atomic_arb_state_e;

endpackage

// File: rtl/atomic_req_arbiter_rr_priority_arbiter.sv
// Combinational round-robin pick: first set request bit scanning upward from
// the slot after i_rr_ptr, wrapping modulo NUM_REQ.
module rr_priority_arbiter
  import atomic_types::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx
);

  logic w_found;

  always_comb begin
    w_found     = 1'b0;
    o_grant_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_found && i_req[(int'(i_rr_ptr) + i) % NUM_REQ]) begin
        w_found     = 1'b1;
        o_grant_idx = ID_W'((int'(i_rr_ptr) + i) % NUM_REQ);
      end
    end
    o_grant = w_found ? (NUM_REQ'(1) << o_grant_idx) : '0;
  end

endmodule

// File: rtl/atomic_req_arbiter.sv
// Round-robin share of one atomic_unit among NUM_REQ requesters, with an
// in-order ID FIFO for response routing. Define ATOMIC_ARB_PERF_EN for counters.
module atomic_req_arbiter
  import atomic_types::*;
#(
  parameter  int NUM_REQ         = 4,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int ID_W            = $clog2(NUM_REQ),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      in_valid,
  output logic [NUM_REQ-1:0]      in_ready,
  input  logic [4*NUM_REQ-1:0]    in_op,
  input  logic [32*NUM_REQ-1:0]   in_address,
  input  logic [32*NUM_REQ-1:0]   in_data,
  input  logic [32*NUM_REQ-1:0]   in_compare_data,
  input  logic [6*NUM_REQ-1:0]    in_warp_id,
  input  logic [5*NUM_REQ-1:0]    in_lane_id,
  output logic [NUM_REQ-1:0]      out_resp_valid,
  input  logic [NUM_REQ-1:0]      out_resp_ready,
  output logic [31:0]             out_resp_data,
  output logic [5:0]              out_resp_warp_id,
  output logic [4:0]              out_resp_lane_id,
  output logic                    au_req_valid,
  input  logic                    au_req_ready,
  output logic [3:0]              au_req_op,
  output logic [31:0]             au_req_address,
  output logic [31:0]             au_req_data,
  output logic [31:0]             au_req_compare_data,
  output logic [5:0]              au_req_warp_id,
  output logic [4:0]              au_req_lane_id,
  input  logic                    au_resp_valid,
  output logic                    au_resp_ready,
  input  logic [31:0]             au_resp_data,
  input  logic [5:0]              au_resp_warp_id,
  input  logic [4:0]              au_resp_lane_id,
  output logic [CNT_W-1:0]        outstanding,
  output logic                    orphan_err,
  output logic [31:0]             grant_count,
  output logic [31:0]             conflict_count
);

  localparam int PTR_W = CNT_W - 1;

  atomic_arb_state_e r_state, w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr, w_win_idx, w_head;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic               w_can_grant, w_grant, w_empty, w_pop, w_orphan;
  logic [ID_W-1:0]    r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_orphan_err;
  atomic_op_e         r_req_op;
  logic [31:0]        r_req_address, r_req_data, r_req_compare_data;
  logic [5:0]         r_req_warp_id;
  logic [4:0]         r_req_lane_id;

  rr_priority_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req       (in_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_win_onehot),
    .o_grant_idx (w_win_idx)
  );

  // Credit uses the registered occupancy only; a same-cycle pop frees nothing.
  assign w_can_grant = ((r_state == ARB_IDLE) || au_req_ready) &&
                       (r_count < CNT_W'(MAX_OUTSTANDING));
  assign w_grant     = w_can_grant && (|in_valid);
  assign in_ready    = w_grant ? w_win_onehot : '0;

  // Handshakes: a transfer happens on a clock edge where valid && ready; a
  // valid source holds its payload stable until that edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:  if (w_grant) w_state_nxt = ARB_ISSUE;
      ARB_ISSUE: if (au_req_ready) w_state_nxt = w_grant ? ARB_ISSUE : ARB_IDLE;
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= ARB_IDLE;
      r_rr_ptr           <= ID_W'(NUM_REQ - 1);
      r_req_op           <= ATOM_ADD;
      r_req_address      <= '0;
      r_req_data         <= '0;
      r_req_compare_data <= '0;
      r_req_warp_id      <= '0;
      r_req_lane_id      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_rr_ptr           <= w_win_idx;
        r_req_op           <= atomic_op_e'(in_op[32'(w_win_idx)*4 +: 4]);
        r_req_address      <= in_address[32'(w_win_idx)*32 +: 32];
        r_req_data         <= in_data[32'(w_win_idx)*32 +: 32];
        r_req_compare_data <= in_compare_data[32'(w_win_idx)*32 +: 32];
        r_req_warp_id      <= in_warp_id[32'(w_win_idx)*6 +: 6];
        r_req_lane_id      <= in_lane_id[32'(w_win_idx)*5 +: 5];
      end
    end
  end

  assign au_req_valid        = (r_state == ARB_ISSUE);
  assign au_req_op           = r_req_op;
  assign au_req_address      = r_req_address;
  assign au_req_data         = r_req_data;
  assign au_req_compare_data = r_req_compare_data;
  assign au_req_warp_id      = r_req_warp_id;
  assign au_req_lane_id      = r_req_lane_id;

  assign w_empty  = (r_count == '0);
  assign w_head   = r_fifo[r_rd_ptr];
  assign w_pop    = au_resp_valid && !w_empty && out_resp_ready[w_head];
  assign w_orphan = au_resp_valid && w_empty;

  assign out_resp_valid   = (au_resp_valid && !w_empty) ? (NUM_REQ'(1) << w_head) : '0;
  assign au_resp_ready    = w_empty ? 1'b1 : out_resp_ready[w_head];
  assign out_resp_data    = au_resp_data;
  assign out_resp_warp_id = au_resp_warp_id;
  assign out_resp_lane_id = au_resp_lane_id;

  always_ff @(posedge clk) begin
    if (w_grant) r_fifo[r_wr_ptr] <= w_win_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_orphan_err <= 1'b0;
    end else begin
      if (w_grant) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_orphan) r_orphan_err <= 1'b1;
    end
  end

  assign outstanding = r_count;
  assign orphan_err  = r_orphan_err;

`ifdef ATOMIC_ARB_PERF_EN
  logic [31:0] r_grant_count, r_conflict_count;
  logic        w_conflict;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_conflict = |(in_valid & (in_valid - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_count    <= '0;
      r_conflict_count <= '0;
    end else begin
      if (w_grant && (r_grant_count != '1))       r_grant_count    <= r_grant_count + 1'b1;
      if (w_conflict && (r_conflict_count != '1)) r_conflict_count <= r_conflict_count + 1'b1;
    end
  end

  assign grant_count    = r_grant_count;
  assign conflict_count = r_conflict_count;
`else
  assign grant_count    = '0;
  assign conflict_count = '0;
`endif

endmodule

// File: doc/atomic_req_arbiter.md
Name: atomic_req_arbiter

Overview:
- Shares one atomic_unit between NUM_REQ execution-unit requesters. Typical use is one requester per SM sub-partition.
- Picks one request per cycle using round-robin and issues it through a registered request slot.
- Records the winning requester's index in an in-order ID FIFO, then routes each atomic_unit response back to the requester at the FIFO head.
- Sits between the execution units and atomic_unit.

Parameters:
- NUM_REQ, 4, number of requester ports (2..16).
- MAX_OUTSTANDING, 4, requests issued downstream but not yet answered; this is the ID FIFO depth (power of 2).
- ID_W, $clog2(NUM_REQ), width of a requester index (derived; not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- in_valid  in  NUM_REQ  per-requester request valid.
- in_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- in_op  in  4*NUM_REQ  atomic_op_e per requester.
- in_address  in  32*NUM_REQ  target address.
- in_data  in  32*NUM_REQ  source operand.
- in_compare_data  in  32*NUM_REQ  CAS compare operand.
- in_warp_id  in  6*NUM_REQ  warp id.
- in_lane_id  in  5*NUM_REQ  lane id.
- out_resp_valid  out  NUM_REQ  per-requester response valid (one-hot or zero).
- out_resp_ready  in  NUM_REQ  per-requester response ready.
- out_resp_data  out  32  response data, broadcast to all requesters.
- out_resp_warp_id  out  6  broadcast.
- out_resp_lane_id  out  5  broadcast.
- au_req_valid  out  1  request to atomic_unit.
- au_req_ready  in  1  atomic_unit accepts the request.
- au_req_op  out  4  registered operation.
- au_req_address  out  32  registered address.
- au_req_data  out  32  registered source operand.
- au_req_compare_data  out  32  registered compare operand.
- au_req_warp_id  out  6  registered warp id.
- au_req_lane_id  out  5  registered lane id.
- au_resp_valid  in  1  atomic_unit response valid.
- au_resp_ready  out  1  back-pressure to atomic_unit.
- au_resp_data  in  32  response data.
- au_resp_warp_id  in  6  response warp id.
- au_resp_lane_id  in  5  response lane id.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current ID FIFO occupancy.
- orphan_err  out  1  sticky: response arrived while the FIFO was empty.
- grant_count  out  32  performance counter (optional feature).
- conflict_count  out  32  performance counter (optional feature).

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - FSM goes to IDLE.
  - au_req_valid=0 and all au_req_* payload = 0.
  - ID FIFO emptied; outstanding=0.
  - Round-robin pointer rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - orphan_err=0; counters=0.
- Reset mid-operation discards the held request and all FIFO entries. Responses arriving later are orphans.
- FSM states:
  - IDLE: slot empty.
  - ISSUE: au_req_valid=1; payload held stable until au_req_ready.
- can_grant = (state==IDLE, or ISSUE and au_req_ready) and outstanding < MAX_OUTSTANDING.
  - A same-cycle response pop does NOT give credit to the grant decision.
- Arbitration, when can_grant and any in_valid:
  - Winner w = first valid index scanning rr_ptr+1, rr_ptr+2, …, wrapping modulo NUM_REQ.
  - in_ready[w]=1 combinationally; all other in_ready bits are 0.
- On the grant edge:
  - Load the slot with requester w's payload.
  - Push w into the FIFO; rr_ptr <= w.
  - Next state = ISSUE.
- Latency: in handshake at edge N; au_req_valid high from N+1.
- Back-to-back issue is allowed: ISSUE with au_req_ready and a new grant stays in ISSUE with the new payload.
- ISSUE with au_req_ready and no grant → IDLE.
- Only a single requester valid: it wins regardless of rr_ptr.
- in_valid deasserting without a handshake is allowed; no state change results.
- Response routing (h = FIFO head):
  - out_resp_valid[h] = au_resp_valid && FIFO non-empty.
  - au_resp_ready = out_resp_ready[h] when the FIFO is non-empty.
  - The handshake pops the FIFO.
  - out_resp_* data fields pass through combinationally from au_resp_*.
- Orphan response (au_resp_valid with the FIFO empty):
  - au_resp_ready=1 and the response is dropped.
  - orphan_err is set and stays set until reset.
- Same-cycle push and pop: occupancy unchanged.
- FIFO pointers wrap modulo MAX_OUTSTANDING.

Optional Feature:
- Macro ATOMIC_ARB_PERF_EN.
- Defined:
  - grant_count increments on every in handshake.
  - conflict_count increments on every cycle with two or more in_valid bits set.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package atomic_types: reuse atomic_op_e; add arbiter state enum atomic_arb_state_e {ARB_IDLE, ARB_ISSUE}.
- One sub-module: rr_priority_arbiter.
  - Combinational, parameter NUM_REQ.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant and the binary index.
- The ID FIFO stays inline.

Test Plan:
- All four in_valid held high, au_req_ready=1, after reset → grants in order 0,1,2,3,0. au_req_valid first seen one cycle after the first handshake. Issue stalls after 4 grants (FIFO full) until a response pops.
- Requester 2 only, address 0x100, op ADD, data 5 → au_req_* carries those values one cycle later. When au_resp data 0x7 arrives, out_resp_valid=4'b0100 with out_resp_data=0x7.
- au_req_ready held low for 3 cycles with au_req_valid high → payload unchanged, in_ready all 0 until au_req_ready rises.
- Requesters 1 then 3 issued; responses A then B → A goes to requester 1 and B to requester 3. With out_resp_ready[1]=0, au_resp_ready=0 until it rises.
- au_resp_valid pulse after reset with nothing issued → au_resp_ready=1, orphan_err=1 and sticky. The next rst pulse clears it.
- With ATOMIC_ARB_PERF_EN defined: 10 cycles with requesters 0 and 1 both valid → conflict_count=10 and grant_count equals the number of handshakes. Without the macro both counters read 0.
